// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared AHB encodings, FSM states and lane helpers.
// Optional privilege check macro: AHB_SRAM_PRIV_CHECK_EN.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic [7:0] byte_en(
    input logic [2:0] size,
    input logic [2:0] lsbs
  );
    logic [7:0] m;
    unique case (size)
      HSIZE_BYTE: m = 8'h01;
      HSIZE_HALF: m = 8'h03;
      HSIZE_WORD: m = 8'h0f;
      default:    m = 8'hff;
    endcase
    return m << lsbs;
  endfunction

endpackage

// File: rtl/ahb_sram_if.sv
// ahb_sram_if: AHB-Lite slave-side signal bundle.
// Optional privilege check macro: AHB_SRAM_PRIV_CHECK_EN.
interface ahb_sram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY_IN;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE,
    output HSIZE, HBURST, HPROT, HWDATA,
    output HREADY_IN,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE,
    input  HSIZE, HBURST, HPROT, HWDATA,
    input  HREADY_IN,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: word array, byte-enabled sync write, async read.
// Optional privilege check macro: AHB_SRAM_PRIV_CHECK_EN.
module ahb_sram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM target with wait states and ERROR.
// Optional privilege check macro: AHB_SRAM_PRIV_CHECK_EN.
module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic       hclk,
  input logic       hreset,
  ahb_sram_if.slave bus
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       ready_q, ready_n;
  logic [1:0] resp_q, resp_n;

  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_write;
  logic [2:0]            a_size;

  logic can_take, accept, bad;
  logic oor, misal, oversz, priv_err;

  logic [2:0]            lsb;
  logic [7:0]            be8;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign can_take = (state == ST_IDLE) ||
                    (state == ST_DATA) ||
                    (state == ST_ERR2);
  assign accept = can_take & bus.HSEL &
                  bus.HREADY_IN & bus.HTRANS[1];

  assign oor = |(bus.HADDR >> (OFF + AW));
  assign misal = |(bus.HADDR[6:0] &
                   ((7'd1 << bus.HSIZE) - 7'd1));
  assign oversz = bus.HSIZE > 3'(OFF);

`ifdef AHB_SRAM_PRIV_CHECK_EN
  // user-mode access to the upper half of memory is refused
  assign priv_err = ~bus.HPROT[1] &
                    bus.HADDR[OFF+AW-1];
`else
  assign priv_err = 1'b0;
`endif

  assign bad = oor | misal | oversz | priv_err;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = ST_DATA;
      end
      ST_ERR1: state_n = ST_ERR2;
      default: begin
        state_n = ST_IDLE;
        if (accept) begin
          if (bad) begin
            state_n = ST_ERR1;
          end else if (WS != 4'd0) begin
            state_n = ST_WAIT;
            cnt_n   = WS;
          end else begin
            state_n = ST_DATA;
          end
        end
      end
    endcase
    ready_n = !((state_n == ST_WAIT) ||
                (state_n == ST_ERR1));
    resp_n  = ((state_n == ST_ERR1) ||
               (state_n == ST_ERR2)) ?
              HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ready_q <= ready_n;
      resp_q  <= resp_n;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      a_addr  <= '0;
      a_write <= 1'b0;
      a_size  <= 3'd0;
    end else if (accept) begin
      a_addr  <= bus.HADDR;
      a_write <= bus.HWRITE;
      a_size  <= bus.HSIZE;
    end
  end

  assign lsb    = a_addr[2:0] & 3'(NB - 1);
  assign be8    = byte_en(a_size, lsb);
  assign mem_we = (state == ST_DATA) & a_write;

  ahb_sram_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (AW)
  ) u_mem (
    .clk   (hclk),
    .we    (mem_we),
    .be    (be8[NB-1:0]),
    .addr  (a_addr[OFF +: AW]),
    .wdata (bus.HWDATA),
    .rdata (mem_rdata)
  );

  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;
  assign bus.HRDATA    =
    ((state == ST_DATA) && !a_write) ?
    mem_rdata : '0;

  logic unused_sink;
  assign unused_sink = ^{bus.HBURST, bus.HPROT,
                         bus.HTRANS[0], a_addr, be8};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed table plus corner sequences.
// Priv-check expectations follow AHB_SRAM_PRIV_CHECK_EN.
module tb_ahb_sram_slave;
  import ahb_sram_pkg::*;

`ifdef AHB_SRAM_PRIV_CHECK_EN
  localparam bit PRIV = 1'b1;
`else
  localparam bit PRIV = 1'b0;
`endif

  logic hclk = 1'b0;
  logic hreset;
  always #5 hclk = ~hclk;

  logic        hsel, hwrite, use3, hrdy_force;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;

  ahb_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b0 ();
  ahb_sram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b3 ();

  logic        ready;
  logic [1:0]  resp;
  logic [31:0] rdata_o;

  assign ready   = use3 ? b3.HREADYOUT : b0.HREADYOUT;
  assign resp    = use3 ? b3.HRESP : b0.HRESP;
  assign rdata_o = use3 ? b3.HRDATA : b0.HRDATA;

  assign b0.HSEL      = hsel & ~use3;
  assign b0.HADDR     = haddr;
  assign b0.HTRANS    = htrans;
  assign b0.HWRITE    = hwrite;
  assign b0.HSIZE     = hsize;
  assign b0.HBURST    = 3'd0;
  assign b0.HPROT     = hprot;
  assign b0.HWDATA    = hwdata;
  assign b0.HREADY_IN = hrdy_force & ready;

  assign b3.HSEL      = hsel & use3;
  assign b3.HADDR     = haddr;
  assign b3.HTRANS    = htrans;
  assign b3.HWRITE    = hwrite;
  assign b3.HSIZE     = hsize;
  assign b3.HBURST    = 3'd0;
  assign b3.HPROT     = hprot;
  assign b3.HWDATA    = hwdata;
  assign b3.HREADY_IN = hrdy_force & ready;

  ahb_sram_slave #(.WAIT_STATES(0)) u0 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (b0)
  );

  ahb_sram_slave #(.WAIT_STATES(3)) u3 (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (b3)
  );

  typedef struct {
    bit          dut;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] wdata;
    bit          err;
    bit          chk;
    logic [31:0] rdata;
  } vec_t;

  vec_t vq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(
    bit d, bit w, logic [31:0] a, logic [2:0] s,
    logic [3:0] p, logic [31:0] wd, bit e, bit c,
    logic [31:0] rd);
    vec_t v;
    v.dut = d; v.wr = w; v.addr = a; v.size = s;
    v.prot = p; v.wdata = wd; v.err = e;
    v.chk = c; v.rdata = rd;
    return v;
  endfunction

  task automatic xfer(input bit d, input bit wr,
                      input logic [31:0] a,
                      input logic [2:0] s,
                      input logic [3:0] p,
                      input logic [31:0] wd,
                      output bit err, output int waits,
                      output logic [31:0] rd);
    bit done;
    use3 = d; hsel = 1'b1; htrans = HTRANS_NONSEQ;
    haddr = a; hwrite = wr; hsize = s; hprot = p;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
    err = 1'b0; waits = 0; rd = '0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (resp == HRESP_ERROR) err = 1'b1;
      if (ready) begin
        rd = rdata_o;
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge hclk); #1;
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          e;
    int          w;
    logic [31:0] r;
    int          ew;

    vq.push_back(mk(0,1,32'h10,2,2,32'h11223344,0,0,0));
    vq.push_back(mk(0,1,32'h13,0,2,32'hAA556677,0,0,0));
    vq.push_back(mk(0,0,32'h10,2,2,0,0,1,32'hAA223344));
    vq.push_back(mk(0,1,32'h00,2,2,32'hCAFEF00D,0,0,0));
    vq.push_back(mk(0,1,32'h02,2,2,32'h12345678,1,0,0));
    vq.push_back(mk(0,0,32'h00,2,2,0,0,1,32'hCAFEF00D));
    vq.push_back(mk(0,1,32'h04,2,2,32'h00000000,0,0,0));
    vq.push_back(mk(0,1,32'h06,1,2,32'hBEEF1234,0,0,0));
    vq.push_back(mk(0,0,32'h04,2,2,0,0,1,32'hBEEF0000));
    vq.push_back(mk(0,0,32'h1000,2,2,0,1,1,32'h0));
    vq.push_back(mk(0,0,32'h01,0,2,0,0,1,32'hCAFEF00D));
    vq.push_back(mk(0,1,32'h08,3,2,32'h0,1,0,0));
    vq.push_back(mk(1,1,32'h20,2,2,32'h5A5AA5A5,0,0,0));
    vq.push_back(mk(1,0,32'h20,2,2,0,0,1,32'h5A5AA5A5));
    vq.push_back(mk(1,0,32'h03,1,2,0,1,1,32'h0));
    vq.push_back(mk(0,1,32'h800,2,0,32'h11111111,PRIV,0,0));
    vq.push_back(mk(0,1,32'h800,2,2,32'h22222222,0,0,0));
    vq.push_back(mk(0,0,32'h800,2,2,0,0,1,32'h22222222));
    vq.push_back(mk(0,1,32'h804,2,2,32'h33333333,0,0,0));
    vq.push_back(mk(0,1,32'h804,2,0,32'h44444444,PRIV,0,0));
    vq.push_back(mk(0,0,32'h804,2,2,0,0,1,
                    PRIV ? 32'h33333333 : 32'h44444444));

    hreset = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE;
    hwrite = 1'b0; haddr = '0; hsize = 3'd2;
    hprot = 4'd2; hwdata = '0; use3 = 1'b0;
    hrdy_force = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    check("rst_rdy0", {31'd0, b0.HREADYOUT}, 32'd1);
    check("rst_rdy3", {31'd0, b3.HREADYOUT}, 32'd1);
    check("rst_resp0", {30'd0, b0.HRESP}, 32'd0);
    check("rst_rdata3", b3.HRDATA, 32'd0);
    hreset = 1'b0;
    @(posedge hclk); #1;

    foreach (vq[i]) begin
      xfer(vq[i].dut, vq[i].wr, vq[i].addr, vq[i].size,
           vq[i].prot, vq[i].wdata, e, w, r);
      ew = vq[i].err ? 1 : (vq[i].dut ? 3 : 0);
      check($sformatf("v%0d_err", i), {31'd0, e},
            {31'd0, vq[i].err});
      check($sformatf("v%0d_waits", i), 32'(w), 32'(ew));
      if (vq[i].chk)
        check($sformatf("v%0d_rdata", i), r, vq[i].rdata);
    end

    // back-to-back write then read, zero waits
    use3 = 1'b0; hsel = 1'b1; htrans = HTRANS_NONSEQ;
    haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
    hprot = 4'd2;
    @(posedge hclk); #1;
    check("b2b_w_rdy", {31'd0, ready}, 32'd1);
    check("b2b_w_resp", {30'd0, resp}, 32'd0);
    hwrite = 1'b0; hwdata = 32'hDEADBEEF;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    check("b2b_r_rdy", {31'd0, ready}, 32'd1);
    check("b2b_r_resp", {30'd0, resp}, 32'd0);
    check("b2b_r_data", rdata_o, 32'hDEADBEEF);
    @(posedge hclk); #1;
    check("b2b_idle_rdy", {31'd0, ready}, 32'd1);
    check("b2b_idle_data", rdata_o, 32'd0);

    // BUSY and HREADY_IN=0 must not start a write
    hsel = 1'b1; htrans = HTRANS_BUSY; hwrite = 1'b1;
    haddr = 32'h0; hsize = 3'd2;
    @(posedge hclk); #1;
    check("busy_rdy", {31'd0, ready}, 32'd1);
    hwdata = 32'hFFFFFFFF;
    htrans = HTRANS_NONSEQ; hrdy_force = 1'b0;
    @(posedge hclk); #1;
    hrdy_force = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE;
    check("nrdy_rdy", {31'd0, ready}, 32'd1);
    check("nrdy_resp", {30'd0, resp}, 32'd0);
    @(posedge hclk); #1;
    xfer(0, 0, 32'h0, 2, 2, 0, e, w, r);
    check("ign_data", r, 32'hCAFEF00D);

    // reset during WAIT drops the pending write
    xfer(1, 1, 32'h24, 2, 2, 32'h01020304, e, w, r);
    use3 = 1'b1; hsel = 1'b1; htrans = HTRANS_NONSEQ;
    hwrite = 1'b1; haddr = 32'h24; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    hwdata = 32'h99999999;
    check("rst_wait_rdy", {31'd0, ready}, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b1;
    #1;
    check("mid_rst_rdy", {31'd0, b3.HREADYOUT}, 32'd1);
    check("mid_rst_resp", {30'd0, b3.HRESP}, 32'd0);
    check("mid_rst_data", b3.HRDATA, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    @(posedge hclk); #1;
    xfer(1, 0, 32'h24, 2, 2, 0, e, w, r);
    check("rst_drop_err", {31'd0, e}, 32'd0);
    check("rst_drop_waits", 32'(w), 32'd3);
    check("rst_drop_data", r, 32'h01020304);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
